iterative_alu: RTL

ITERATIVE_ALU -- requirements
Module: iterative_alu

---
 rtl/alu_pkg.sv | 28 ++
 rtl/iterative_alu_if.sv | 29 ++
 rtl/alu_core.sv | 41 ++++
 rtl/iterative_alu.sv | 110 +++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// alu_pkg -- definitions shared by the iterative ALU and alu_control.
//   OP_*        4-bit ALU op codes. 1010-1111 are unassigned and execute as ADD.
//   state_t     sequencer states of iterative_alu.
//   is_shift_op true for the three ops that take the multi-cycle shift path.
package alu_pkg;

  localparam logic [3:0] OP_ADD  = 4'b0000;
  localparam logic [3:0] OP_SLL  = 4'b0001;
  localparam logic [3:0] OP_SLT  = 4'b0010;
  localparam logic [3:0] OP_SLTU = 4'b0011;
  localparam logic [3:0] OP_XOR  = 4'b0100;
  localparam logic [3:0] OP_SRL  = 4'b0101;
  localparam logic [3:0] OP_SRA  = 4'b0110;
  localparam logic [3:0] OP_OR   = 4'b0111;
  localparam logic [3:0] OP_AND  = 4'b1000;
  localparam logic [3:0] OP_SUB  = 4'b1001;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  function automatic logic is_shift_op(input logic [3:0] op);
    return (op == OP_SLL) || (op == OP_SRL) || (op == OP_SRA);
  endfunction

endpackage

// File: rtl/iterative_alu_if.sv
// iterative_alu_if -- request/response bundle of the iterative ALU.
//   Request : in_valid, in_ready, alu_controller[3:0], op_a, op_b
//   Response: out_valid, out_ready, result, zero
//   Status  : busy
// master = requester/consumer side, slave = the ALU.
interface iterative_alu_if #(
  parameter int XLEN = 32
);
  logic            in_valid;
  logic            in_ready;
  logic [3:0]      alu_controller;
  logic [XLEN-1:0] op_a;
  logic [XLEN-1:0] op_b;
  logic            out_valid;
  logic            out_ready;
  logic [XLEN-1:0] result;
  logic            zero;
  logic            busy;

  modport master (
    output in_valid, alu_controller, op_a, op_b, out_ready,
    input  in_ready, out_valid, result, zero, busy
  );

  modport slave (
    input  in_valid, alu_controller, op_a, op_b, out_ready,
    output in_ready, out_valid, result, zero, busy
  );
endinterface

// File: rtl/alu_core.sv
// alu_core -- combinational single-cycle ALU operations.
//   op  [3:0]  op code (alu_pkg::OP_*)
//   a, b       operands
//   y          result: ADD/SUB wrap, SLT/SLTU give 0/1 zero-extended.
// Shift codes and unassigned codes fall through to ADD; iterative_alu never
// takes a shift result from here.
module alu_core
  import alu_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [3:0]      op,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  output logic [XLEN-1:0] y
);

  logic signed [XLEN-1:0] a_s;
  logic signed [XLEN-1:0] b_s;
  logic                   lt_s;
  logic                   lt_u;

  assign a_s  = a;
  assign b_s  = b;
  assign lt_s = a_s < b_s;
  assign lt_u = a < b;

  always_comb begin
    y = a + b;
    case (op)
      OP_SUB:  y = a - b;
      OP_SLT:  y = {{(XLEN-1){1'b0}}, lt_s};
      OP_SLTU: y = {{(XLEN-1){1'b0}}, lt_u};
      OP_XOR:  y = a ^ b;
      OP_OR:   y = a | b;
      OP_AND:  y = a & b;
      default: y = a + b;
    endcase
  end

endmodule

// File: rtl/iterative_alu.sv
// iterative_alu -- ALU with single-cycle arithmetic/logic ops and a
// bit-serial shifter (one bit position per clock).
//   clk, rst_n   clock, synchronous active-low reset
//   bus (slave)  in_valid/in_ready request handshake with alu_controller,
//                op_a, op_b (op_b[SHAMT_W-1:0] = shift amount);
//                out_valid/out_ready response handshake with registered
//                result and zero; busy = not IDLE.
// One operation in flight; DONE always returns to IDLE for a cycle before
// the next request can be taken.
module iterative_alu
  import alu_pkg::*;
#(
  parameter int XLEN    = 32,
  parameter int SHAMT_W = 5
) (
  input  logic            clk,
  input  logic            rst_n,
  iterative_alu_if.slave  bus
);

  state_t               state;
  logic [SHAMT_W-1:0]   cnt;
  logic [XLEN-1:0]      work;
  logic [3:0]           op_q;
  logic [XLEN-1:0]      result_q;
  logic                 zero_q;

  logic                 accept;
  logic [SHAMT_W-1:0]   shamt;
  logic [XLEN-1:0]      core_y;
  logic [XLEN-1:0]      shift_nxt;

  assign accept = bus.in_valid && (state == IDLE);
  assign shamt  = bus.op_b[SHAMT_W-1:0];

  alu_core #(.XLEN(XLEN)) u_core (
    .op (bus.alu_controller),
    .a  (bus.op_a),
    .b  (bus.op_b),
    .y  (core_y)
  );

  // One-bit step of the shift held in op_q; SRA copies the sign bit down.
  always_comb begin
    shift_nxt = work;
    case (op_q)
      OP_SLL:  shift_nxt = {work[XLEN-2:0], 1'b0};
      OP_SRL:  shift_nxt = {1'b0, work[XLEN-1:1]};
      OP_SRA:  shift_nxt = {work[XLEN-1], work[XLEN-1:1]};
      default: shift_nxt = work;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= IDLE;
      cnt      <= '0;
      work     <= '0;
      op_q     <= OP_ADD;
      result_q <= '0;
      zero_q   <= 1'b1;
    end else begin
      case (state)
        // Accept: operands are used only here (or copied into work), so
        // later changes on the request inputs cannot affect the result.
        IDLE: begin
          if (accept) begin
            op_q <= bus.alu_controller;
            if (is_shift_op(bus.alu_controller) && (shamt != '0)) begin
              work  <= bus.op_a;
              cnt   <= shamt;
              state <= SHIFT;
            end else if (is_shift_op(bus.alu_controller)) begin
              result_q <= bus.op_a;
              zero_q   <= (bus.op_a == '0);
              state    <= DONE;
            end else begin
              result_q <= core_y;
              zero_q   <= (core_y == '0);
              state    <= DONE;
            end
          end
        end
        // Shift: the step that takes cnt from 1 to 0 is the last one, so its
        // value goes straight to the result register.
        SHIFT: begin
          work <= shift_nxt;
          cnt  <= cnt - SHAMT_W'(1);
          if (cnt == SHAMT_W'(1)) begin
            result_q <= shift_nxt;
            zero_q   <= (shift_nxt == '0);
            state    <= DONE;
          end
        end
        // Done: hold the result until the consumer takes it.
        DONE: begin
          if (bus.out_ready) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.in_ready  = (state == IDLE);
  assign bus.out_valid = (state == DONE);
  assign bus.busy      = (state != IDLE);
  assign bus.result    = result_q;
  assign bus.zero      = zero_q;

endmodule
